// File: rtl/receptor_param.sv
// receptor_param: oversampled UART receiver, LSB-first, one start bit.
// Define RECEPTOR_PARITY_EN to add a parity bit stage and parity_err.
module receptor_param #(
  parameter int BITS_DATA  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 rx,
  input  logic                 s_tick,
  input  logic                 i_parity_odd,
  output logic                 rx_done_tick,
  output logic [BITS_DATA-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam int TMAX =
    (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TW = $clog2(TMAX);
  localparam int NW = $clog2(BITS_DATA);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(BITS_DATA - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef RECEPTOR_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic [2:0]           state;
  logic [TW-1:0]        ticks;
  logic [NW-1:0]        n;
  logic [BITS_DATA-1:0] buffer;
  logic                 rx_meta;
  logic                 rx_s;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef RECEPTOR_PARITY_EN
  logic par_bit;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else if (s_tick) begin
      if (state == PARITY && ticks == T_BIT)
        par_bit <= rx_s;
      if (state == STOP && ticks == T_STOP)
        parity_err <= ^buffer ^ par_bit ^ i_parity_odd;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = i_parity_odd;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      ticks        <= '0;
      n            <= '0;
      buffer       <= '0;
      data_out     <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            ticks <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (ticks == T_HALF) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                ticks <= '0;
                n     <= '0;
              end
            end else begin
              ticks <= ticks + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (ticks == T_BIT) begin
              ticks  <= '0;
              buffer <= {rx_s, buffer[BITS_DATA-1:1]};
              if (n == N_LAST)
                state <= AFTER_DATA;
              else
                n <= n + 1'b1;
            end else begin
              ticks <= ticks + 1'b1;
            end
          end
        end
`ifdef RECEPTOR_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (ticks == T_BIT) begin
              ticks <= '0;
              state <= STOP;
            end else begin
              ticks <= ticks + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (ticks == T_STOP) begin
              ticks        <= '0;
              rx_done_tick <= 1'b1;
              data_out     <= buffer;
              frame_err    <= ~rx_s;
              // a low line here is a break: wait for idle before rearming
              state        <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              ticks <= ticks + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_receptor_param.sv
// tb_receptor_param: randomized frames against a behavioural UART model.
// Instance a uses defaults, instance b uses 7 data bits and 2 stop bits.
module tb_receptor_param;
  localparam int OS = 16;
`ifdef RECEPTOR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       i_parity_odd = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       done_a, done_b;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       ferr_a, ferr_b, perr_a, perr_b;

  int checks = 0;
  int failures = 0;
  int tick_idx = 0;
  int tick_div = 0;
  int done_cnt [2] = '{0, 0};
  int done_at [2] = '{0, 0};
  logic [8:0] cap_data [2];
  logic cap_ferr [2];
  logic cap_perr [2];

  receptor_param dut_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .rx(rx_a),
    .s_tick(s_tick), .i_parity_odd(i_parity_odd),
    .rx_done_tick(done_a), .data_out(dout_a),
    .frame_err(ferr_a), .parity_err(perr_a)
  );

  receptor_param #(.BITS_DATA(7), .OVERSAMPLE(16),
                   .STOP_TICKS(32)) dut_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .rx(rx_b),
    .s_tick(s_tick), .i_parity_odd(i_parity_odd),
    .rx_done_tick(done_b), .data_out(dout_b),
    .frame_err(ferr_b), .parity_err(perr_b)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    tick_div = (tick_div + 1) % 6;
    s_tick = (tick_div == 0);
  end

  always @(posedge i_clk)
    if (s_tick) tick_idx++;

  always @(negedge i_clk) begin
    if (done_a) begin
      done_cnt[0]++;
      done_at[0] = tick_idx;
      cap_data[0] = {1'b0, dout_a};
      cap_ferr[0] = ferr_a;
      cap_perr[0] = perr_a;
    end
    if (done_b) begin
      done_cnt[1]++;
      done_at[1] = tick_idx;
      cap_data[1] = {2'b0, dout_b};
      cap_ferr[1] = ferr_b;
      cap_perr[1] = perr_b;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] f_dout(int sel);
    return (sel != 0) ? {2'b0, dout_b} : {1'b0, dout_a};
  endfunction
  function automatic logic f_ferr(int sel);
    return (sel != 0) ? ferr_b : ferr_a;
  endfunction
  function automatic logic f_perr(int sel);
    return (sel != 0) ? perr_b : perr_a;
  endfunction

  // reference: parity error = xor of data bits, parity bit and odd select
  function automatic logic exp_perr(logic [8:0] d, int nb,
                                    logic pb, logic odd);
    logic x;
    x = pb ^ odd;
    for (int k = 0; k < nb; k++) x = x ^ d[k];
    return PAR ? x : 1'b0;
  endfunction

  function automatic int exp_lat(int nb, int stop);
    return OS / 2 + OS * nb + OS * int'(PAR) + stop;
  endfunction

  function automatic logic [8:0] mask(logic [8:0] d, int nb);
    logic [8:0] m;
    m = 9'((1 << nb) - 1);
    return d & m;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge i_clk); while (!s_tick);
    end
    @(negedge i_clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel != 0) rx_b = v;
    else rx_a = v;
  endtask

  task automatic run_frame(input int sel, input logic [8:0] d,
                           input int nb, input int stop_len,
                           input logic stop_v, input logic pb,
                           output int nd, output int lat,
                           output logic hold_ok);
    int c0, fall;
    logic [8:0] d0;
    logic f0, p0;
    c0 = done_cnt[sel];
    d0 = f_dout(sel);
    f0 = f_ferr(sel);
    p0 = f_perr(sel);
    fall = tick_idx;
    set_rx(sel, 1'b0);
    wait_ticks(OS);
    for (int k = 0; k < nb; k++) begin
      set_rx(sel, d[k]);
      wait_ticks(OS);
    end
    if (PAR) begin
      set_rx(sel, pb);
      wait_ticks(OS);
    end
    set_rx(sel, stop_v);
    wait_ticks(2);
    hold_ok = (f_dout(sel) === d0) && (f_ferr(sel) === f0) &&
              (f_perr(sel) === p0) && (done_cnt[sel] == c0);
    wait_ticks(stop_len - 2);
    nd = done_cnt[sel] - c0;
    lat = done_at[sel] - fall;
    if (stop_v) set_rx(0 + sel, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      rx_a = 1'($urandom);
      rx_b = 1'($urandom);
    end
    checks++;
    if ({dout_a, ferr_a, perr_a, done_a} !== 11'd0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0",
               {dout_a, ferr_a, perr_a, done_a});
    end
    checks++;
    if ({dout_b, ferr_b, perr_b, done_b} !== 10'd0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0",
               {dout_b, ferr_b, perr_b, done_b});
    end
    rx_a = 1'b1;
    rx_b = 1'b1;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    wait_ticks(20);
    checks++;
    if (done_cnt[0] + done_cnt[1] != 0) begin
      failures++;
      $display("FAIL reset_nodone got=%0d exp=0",
               done_cnt[0] + done_cnt[1]);
    end
  endtask

  task automatic test_basic();
    int nd, lat;
    logic h;
    logic [8:0] d;
    d = 9'h0A5;
    run_frame(0, d, 8, 16, 1'b1, ^d[7:0], nd, lat, h);
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL basic_done got=%0d exp=1", nd);
    end
    checks++;
    if (cap_data[0] !== 9'h0A5 || cap_ferr[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_data got=%h/%b exp=a5/0",
               cap_data[0], cap_ferr[0]);
    end
    checks++;
    if (lat != exp_lat(8, 16) || h !== 1'b1) begin
      failures++;
      $display("FAIL basic_lat got=%0d/%b exp=%0d/1",
               lat, h, exp_lat(8, 16));
    end
  endtask

  task automatic test_false_start();
    int c0, nd, lat;
    logic h;
    c0 = done_cnt[0];
    rx_a = 1'b0;
    wait_ticks(4);
    rx_a = 1'b1;
    wait_ticks(30);
    checks++;
    if (done_cnt[0] != c0) begin
      failures++;
      $display("FAIL false_start got=%0d exp=%0d", done_cnt[0], c0);
    end
    run_frame(0, 9'h03C, 8, 16, 1'b1, 1'b0, nd, lat, h);
    checks++;
    if (nd != 1 || cap_data[0] !== 9'h03C) begin
      failures++;
      $display("FAIL after_false got=%0d/%h exp=1/3c",
               nd, cap_data[0]);
    end
  endtask

  task automatic test_frame_err();
    int c0, nd, lat;
    logic h;
    c0 = done_cnt[0];
    run_frame(0, 9'h03C, 8, 16, 1'b0, 1'b0, nd, lat, h);
    wait_ticks(48);
    checks++;
    if (done_cnt[0] - c0 != 1) begin
      failures++;
      $display("FAIL break_done got=%0d exp=1", done_cnt[0] - c0);
    end
    checks++;
    if (cap_data[0] !== 9'h03C || cap_ferr[0] !== 1'b1 ||
        ferr_a !== 1'b1) begin
      failures++;
      $display("FAIL frame_err got=%h/%b/%b exp=3c/1/1",
               cap_data[0], cap_ferr[0], ferr_a);
    end
    rx_a = 1'b1;
    wait_ticks(4);
    run_frame(0, 9'h096, 8, 16, 1'b1, 1'b0, nd, lat, h);
    checks++;
    if (nd != 1 || cap_data[0] !== 9'h096 || cap_ferr[0] !== 1'b0) begin
      failures++;
      $display("FAIL after_break got=%0d/%h/%b exp=1/96/0",
               nd, cap_data[0], cap_ferr[0]);
    end
  endtask

  task automatic test_parity();
    int nd, lat;
    logic h;
    logic [1:0] pb_odd [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      i_parity_odd = pb_odd[i][0];
      run_frame(0, 9'h007, 8, 16, 1'b1, pb_odd[i][1], nd, lat, h);
      checks++;
      if (nd != 1 || cap_perr[0] !==
          exp_perr(9'h007, 8, pb_odd[i][1], pb_odd[i][0])) begin
        failures++;
        $display("FAIL parity%0d got=%0d/%b exp=1/%b", i, nd,
                 cap_perr[0],
                 exp_perr(9'h007, 8, pb_odd[i][1], pb_odd[i][0]));
      end
    end
    i_parity_odd = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0, nd, lat;
    logic h;
    logic [8:0] d;
    d = 9'h0FF;
    c0 = done_cnt[0];
    rx_a = 1'b0;
    wait_ticks(OS);
    for (int k = 0; k < 4; k++) begin
      rx_a = d[k];
      wait_ticks(OS);
    end
    rx_a = d[4];
    wait_ticks(OS / 2);
    i_reset_n = 1'b0;
    rx_a = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({dout_a, ferr_a, perr_a, done_a} !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0",
               {dout_a, ferr_a, perr_a, done_a});
    end
    i_reset_n = 1'b1;
    wait_ticks(40);
    checks++;
    if (done_cnt[0] != c0) begin
      failures++;
      $display("FAIL mid_nodone got=%0d exp=%0d", done_cnt[0], c0);
    end
    run_frame(0, 9'h05A, 8, 16, 1'b1, 1'b0, nd, lat, h);
    checks++;
    if (nd != 1 || cap_data[0] !== 9'h05A) begin
      failures++;
      $display("FAIL mid_next got=%0d/%h exp=1/5a", nd, cap_data[0]);
    end
  endtask

  task automatic test_bits7();
    int nd, lat;
    logic h;
    run_frame(1, 9'h055, 7, 32, 1'b1, 1'b0, nd, lat, h);
    checks++;
    if (nd != 1 || cap_data[1] !== 9'h055 || cap_ferr[1] !== 1'b0) begin
      failures++;
      $display("FAIL b7_data got=%0d/%h/%b exp=1/55/0",
               nd, cap_data[1], cap_ferr[1]);
    end
    checks++;
    if (lat != exp_lat(7, 32) || h !== 1'b1) begin
      failures++;
      $display("FAIL b7_lat got=%0d/%b exp=%0d/1",
               lat, h, exp_lat(7, 32));
    end
  endtask

  task automatic test_random();
    int nd, lat, sel, nb, st;
    logic h, sv, pb;
    logic [8:0] d;
    for (int i = 0; i < 30; i++) begin
      sel = (i % 5 == 4) ? 1 : 0;
      nb = sel ? 7 : 8;
      st = sel ? 32 : 16;
      d = mask(9'($urandom), nb);
      sv = ($urandom_range(0, 3) != 0);
      pb = 1'($urandom);
      i_parity_odd = 1'($urandom);
      run_frame(sel, d, nb, st, sv, pb, nd, lat, h);
      checks++;
      if (nd != 1 || cap_data[sel] !== d) begin
        failures++;
        $display("FAIL rnd%0d_data got=%0d/%h exp=1/%h",
                 i, nd, cap_data[sel], d);
      end
      checks++;
      if (cap_ferr[sel] !== ~sv ||
          cap_perr[sel] !== exp_perr(d, nb, pb, i_parity_odd)) begin
        failures++;
        $display("FAIL rnd%0d_err got=%b%b exp=%b%b", i,
                 cap_ferr[sel], cap_perr[sel], ~sv,
                 exp_perr(d, nb, pb, i_parity_odd));
      end
      checks++;
      if (lat != exp_lat(nb, st) || h !== 1'b1) begin
        failures++;
        $display("FAIL rnd%0d_lat got=%0d/%b exp=%0d/1",
                 i, lat, h, exp_lat(nb, st));
      end
      if (!sv) begin
        wait_ticks($urandom_range(1, 20));
        set_rx(sel, 1'b1);
        wait_ticks(2);
      end
      if ($urandom_range(0, 1) != 0)
        wait_ticks($urandom_range(1, 5));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_parity();
    test_reset_mid();
    test_bits7();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
